// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: forwarding selects, FSM states, default widths.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_BR_FLUSH = 2'b10
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard inputs and datapath control outputs of the hazard controller.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              ex_branch_taken;

    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall_if;
    logic              stall_id;
    logic              flush_id;
    logic              flush_ex;
    logic              pc_sel;
    logic [1:0]        hz_state;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, ex_branch_taken,
        input  fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, flush_ex, pc_sel,
               hz_state, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, ex_branch_taken,
        output fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, flush_ex, pc_sel,
               hz_state, stall_count, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forwarding comparator: picks MEM, then WB, else register file; x0 never forwarded.
// Purely combinational, zero latency, no flow control.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_we_i,
    output logic [1:0]        sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (src_i != '0) begin
            if (mem_we_i && (mem_rd_i == src_i)) begin
                sel_o = FWD_MEM;
            end else if (wb_we_i && (wb_rd_i == src_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: tracks rd through EX/MEM/WB, drives forwarding selects, stall/flush/pc_sel.
// Controls are combinational from tracking state and current inputs; state/counters update per clock.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);

    logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q, mem_rd_q, wb_rd_q;
    logic              ex_we_q, ex_mr_q, mem_we_q, wb_we_q;
    hz_state_e         state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic       lu, br, stall, flush_ex;
    logic [1:0] fwd_a, fwd_b;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .src_i    (ex_rs1_q),
        .mem_rd_i (mem_rd_q),
        .mem_we_i (mem_we_q),
        .wb_rd_i  (wb_rd_q),
        .wb_we_i  (wb_we_q),
        .sel_o    (fwd_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .src_i    (ex_rs2_q),
        .mem_rd_i (mem_rd_q),
        .mem_we_i (mem_we_q),
        .wb_rd_i  (wb_rd_q),
        .wb_we_i  (wb_we_q),
        .sel_o    (fwd_b)
    );

    // rst_n gating keeps every control low while reset is held, whatever the inputs do.
    always_comb begin
        lu = rst_n & hz.id_valid & ex_mr_q & (ex_rd_q != '0) &
             ((ex_rd_q == hz.id_rs1) | (ex_rd_q == hz.id_rs2));
        br       = rst_n & hz.ex_branch_taken;
        stall    = lu & ~br;
        flush_ex = lu | br;
    end

    assign hz.fwd_a_sel   = rst_n ? fwd_a : FWD_RF;
    assign hz.fwd_b_sel   = rst_n ? fwd_b : FWD_RF;
    assign hz.stall_if    = stall;
    assign hz.stall_id    = stall;
    assign hz.flush_id    = br;
    assign hz.flush_ex    = flush_ex;
    assign hz.pc_sel      = br;
    assign hz.hz_state    = state_q;
    assign hz.stall_count = stall_cnt_q;
    assign hz.flush_count = flush_cnt_q;

    always_comb begin
        state_d     = ST_RUN;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (br) begin
            state_d = ST_BR_FLUSH;
        end else if (lu) begin
            state_d = ST_LU_STALL;
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (br && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_rd_q     <= '0;
            ex_we_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            mem_rd_q    <= '0;
            mem_we_q    <= 1'b0;
            wb_rd_q     <= '0;
            wb_we_q     <= 1'b0;
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            wb_rd_q     <= mem_rd_q;
            wb_we_q     <= mem_we_q;
            mem_rd_q    <= ex_rd_q;
            mem_we_q    <= ex_we_q;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            if (flush_ex) begin
                ex_rs1_q <= '0;
                ex_rs2_q <= '0;
                ex_rd_q  <= '0;
                ex_we_q  <= 1'b0;
                ex_mr_q  <= 1'b0;
            end else begin
                ex_rs1_q <= hz.id_rs1;
                ex_rs2_q <= hz.id_rs2;
                ex_rd_q  <= hz.id_rd;
                ex_we_q  <= hz.id_valid & hz.id_reg_write;
                ex_mr_q  <= hz.id_valid & hz.id_mem_read;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_hazard_ctrl;

    logic clk;
    logic rst_n;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifc ();
    hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  ifs ();

    hazard_ctrl #(.REG_AW(5), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ifc)
    );

    hazard_ctrl #(.REG_AW(5), .CNT_W(2)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ifs)
    );

    typedef struct {
        int         tag;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       stl;
        logic       fid;
        logic       fex;
        logic [1:0] st;
        int         sc;
        int         fc;
        int         sfc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tag_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d: got %0d expected %0d", nm, tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("fwd_a_sel",   e.tag, int'(ifc.fwd_a_sel),   int'(e.fa));
            chk("fwd_b_sel",   e.tag, int'(ifc.fwd_b_sel),   int'(e.fb));
            chk("stall_if",    e.tag, int'(ifc.stall_if),    int'(e.stl));
            chk("stall_id",    e.tag, int'(ifc.stall_id),    int'(e.stl));
            chk("flush_id",    e.tag, int'(ifc.flush_id),    int'(e.fid));
            chk("pc_sel",      e.tag, int'(ifc.pc_sel),      int'(e.fid));
            chk("flush_ex",    e.tag, int'(ifc.flush_ex),    int'(e.fex));
            chk("hz_state",    e.tag, int'(ifc.hz_state),    int'(e.st));
            chk("stall_count", e.tag, int'(ifc.stall_count), e.sc);
            chk("flush_count", e.tag, int'(ifc.flush_count), e.fc);
            chk("sat_flush_count", e.tag, int'(ifs.flush_count), e.sfc);
        end
    end

    // One clock of stimulus to both DUTs plus the expected outputs for that same cycle.
    task automatic cyc(input logic r, input logic v,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic br,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic stl, input logic fid, input logic fex,
                       input logic [1:0] st, input int sc, input int fc);
        exp_t e;
        rst_n               = r;
        ifc.id_valid        = v;   ifs.id_valid        = v;
        ifc.id_rs1          = rs1; ifs.id_rs1          = rs1;
        ifc.id_rs2          = rs2; ifs.id_rs2          = rs2;
        ifc.id_rd           = rd;  ifs.id_rd           = rd;
        ifc.id_reg_write    = rw;  ifs.id_reg_write    = rw;
        ifc.id_mem_read     = mr;  ifs.id_mem_read     = mr;
        ifc.ex_branch_taken = br;  ifs.ex_branch_taken = br;
        e.tag = tag_cnt;
        e.fa  = fa;  e.fb  = fb;
        e.stl = stl; e.fid = fid; e.fex = fex;
        e.st  = st;  e.sc  = sc;  e.fc  = fc;
        e.sfc = (fc > 3) ? 3 : fc;
        exp_q.push_back(e);
        tag_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        // Reset held with random inputs; branch forced high in one cycle.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                (i == 1) ? 1'b1 : 1'($urandom_range(0, 1)),
                2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        end
        // Released, nothing valid: writes gated off, selects stay register file.
        cyc(1, 0, 5, 6, 5, 1, 1, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 0, 5, 6, 5, 1, 1, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        // add x5; add x5; use x5: MEM wins over WB.
        cyc(1, 1, 1, 2, 5, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 1, 3, 4, 5, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 1, 5, 0, 6, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0,  2'b10, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        // Single producer x8 two ahead: WB forward on both operands.
        cyc(1, 1, 0, 0, 8, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 1, 0, 0, 9, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 1, 8, 8, 10, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0,  2'b01, 2'b01, 0, 0, 0, 2'b00, 0, 0);
        // x0 producer/consumer and a load to x0.
        cyc(1, 1, 0, 0, 0, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 1, 0, 0, 11, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 1, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 1, 0, 0, 12, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        // lw x7; use rs2=x7: one stall cycle, then forwarded once the consumer reaches EX.
        cyc(1, 1, 1, 2, 7, 1, 1, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 1, 3, 7, 13, 1, 0, 0, 2'b00, 2'b00, 1, 0, 1, 2'b00, 0, 0);
        cyc(1, 1, 3, 7, 13, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b01, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b01, 0, 0, 0, 2'b00, 1, 0);
        // Back-to-back load-use: lw x7; lw x8,(x7); use x8.
        cyc(1, 1, 1, 0, 7, 1, 1, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 1, 0);
        cyc(1, 1, 7, 0, 8, 1, 1, 0,  2'b00, 2'b00, 1, 0, 1, 2'b00, 1, 0);
        cyc(1, 1, 7, 0, 8, 1, 1, 0,  2'b00, 2'b00, 0, 0, 0, 2'b01, 2, 0);
        cyc(1, 1, 8, 8, 9, 1, 0, 0,  2'b01, 2'b00, 1, 0, 1, 2'b00, 2, 0);
        cyc(1, 1, 8, 8, 9, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b01, 3, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0,  2'b01, 2'b01, 0, 0, 0, 2'b00, 3, 0);
        // Taken branch in the same cycle as a load-use: branch wins.
        cyc(1, 1, 0, 0, 5, 1, 1, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 3, 0);
        cyc(1, 1, 5, 0, 6, 1, 0, 1,  2'b00, 2'b00, 0, 1, 1, 2'b00, 3, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b10, 3, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 3, 1);
        // Reset during a stall drops the hold and clears state/counters.
        cyc(1, 1, 0, 0, 4, 1, 1, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 3, 1);
        cyc(1, 1, 4, 0, 6, 1, 0, 0,  2'b00, 2'b00, 1, 0, 1, 2'b00, 3, 1);
        cyc(0, 1, 4, 0, 6, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 1, 4, 0, 6, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        // Five branch cycles: 2-bit counter saturates at 3.
        cyc(1, 0, 0, 0, 0, 0, 0, 1,  2'b00, 2'b00, 0, 1, 1, 2'b00, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1,  2'b00, 2'b00, 0, 1, 1, 2'b10, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1,  2'b00, 2'b00, 0, 1, 1, 2'b10, 0, 2);
        cyc(1, 0, 0, 0, 0, 0, 0, 1,  2'b00, 2'b00, 0, 1, 1, 2'b10, 0, 3);
        cyc(1, 0, 0, 0, 0, 0, 0, 1,  2'b00, 2'b00, 0, 1, 1, 2'b10, 0, 4);
        cyc(1, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b10, 0, 5);
        cyc(1, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 5);
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
